demultiplexor_1_3_16b: RTL and testbench

Registered 1-to-3 distributor, the write-side counterpart of the 3:1 register-select mux. It takes one 16-bit word with a 2-bit destination selector and a valid/ready handshake. The word is captured into one of three holding registers, each with its own valid flag and a consumer acknowledge. It sits between the datapath result bus and the three operand/result registers the mux later reads back.

---
 rtl/demultiplexor_1_3_16b.sv | 166 ++++++++++++++++
 tb/tb_demultiplexor_1_3_16b.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/demultiplexor_1_3_16b.sv
`default_nettype none
// ============================================================================
// Module      : demultiplexor_1_3_16b
// Description : Registered 1-to-3 distributor. One WIDTH-bit word plus a
//               2-bit destination selector arrives over a valid/ready
//               handshake. The word is captured into one of three holding
//               registers. Each register has its own full flag, which the
//               consumer clears with its Ack bit. Selector value 3 is invalid.
//               A word accepted with Selector==3 is dropped, raises a
//               one-cycle Sel_Error pulse and bumps a saturating Drop_Count.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1          system clock, rising edge
//   reset      in   1          asynchronous reset, active low
//   Data_In    in   WIDTH      word to distribute
//   Selector   in   2          0->REG1, 1->REG2, 2->REG3, 3->invalid (drop)
//   Enable     in   1          block enable; low blocks all acceptance
//   In_Valid   in   1          producer presents Data_In/Selector
//   In_Ready   out  1          block can accept this cycle (combinational)
//   Ack        in   3          per-register consume strobe, bit0=REG1
//   REG1_Out   out  WIDTH      holding register 1
//   REG2_Out   out  WIDTH      holding register 2
//   REG3_Out   out  WIDTH      holding register 3
//   Out_Valid  out  3          per-register full flag, bit0=REG1
//   Sel_Error  out  1          pulse: previous-cycle accept with Selector==3
//   Drop_Count out  CNT_WIDTH  saturating count of dropped words
// ============================================================================
module demultiplexor_1_3_16b #(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     Data_In,
  input  logic [1:0]           Selector,
  input  logic                 Enable,
  input  logic                 In_Valid,
  output logic                 In_Ready,
  input  logic [2:0]           Ack,
  output logic [WIDTH-1:0]     REG1_Out,
  output logic [WIDTH-1:0]     REG2_Out,
  output logic [WIDTH-1:0]     REG3_Out,
  output logic [2:0]           Out_Valid,
  output logic                 Sel_Error,
  output logic [CNT_WIDTH-1:0] Drop_Count
);

  localparam logic [1:0]           c_SEL_INVALID = 2'd3;
  localparam logic [CNT_WIDTH-1:0] c_CNT_MAX     = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] c_CNT_ONE     = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // Per-slot occupancy state.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

  slot_state_t            r_state      [3];
  slot_state_t            w_state_next [3];
  logic [WIDTH-1:0]       r_data       [3];
  logic [2:0]             w_full;
  logic [2:0]             w_slot_ready;
  logic [2:0]             w_load;
  logic                   w_sel_ready;
  logic                   w_accept;
  logic                   w_drop;
  logic                   r_sel_error;
  logic [CNT_WIDTH-1:0]   r_drop_count;

  // --------------------------------------------------------------------------
  // Handshake. A slot can take a word when it is empty, or when the consumer
  // is draining it in this same cycle (one-word-per-cycle pass-through).
  // Only the addressed slot matters; the invalid selector is always ready so
  // a bad word can never stall the producer.
  // --------------------------------------------------------------------------
  always_comb begin
    w_sel_ready = 1'b0;
    case (Selector)
      2'd0:    w_sel_ready = w_slot_ready[0];
      2'd1:    w_sel_ready = w_slot_ready[1];
      2'd2:    w_sel_ready = w_slot_ready[2];
      default: w_sel_ready = 1'b1;
    endcase
  end

  assign In_Ready = Enable & w_sel_ready;
  assign w_accept = In_Valid & In_Ready;
  assign w_drop   = w_accept & (Selector == c_SEL_INVALID);

  // --------------------------------------------------------------------------
  // Holding slots: identical logic replicated three times.
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < 3; gi++) begin : g_slot
    assign w_full[gi]       = (r_state[gi] == FULL);
    assign w_slot_ready[gi] = ~w_full[gi] | Ack[gi];
    assign w_load[gi]       = w_accept & (Selector == gi[1:0]);

    // Next-state: a load always wins over a concurrent Ack so the slot stays
    // FULL with the new word; an Ack on an empty slot is harmless.
    always_comb begin
      w_state_next[gi] = r_state[gi];
      case (r_state[gi])
        EMPTY: begin
          if (w_load[gi]) begin
            w_state_next[gi] = FULL;
          end
        end
        FULL: begin
          if (!w_load[gi] && Ack[gi]) begin
            w_state_next[gi] = EMPTY;
          end
        end
        default: w_state_next[gi] = EMPTY;
      endcase
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_state[gi] <= EMPTY;
      end else begin
        r_state[gi] <= w_state_next[gi];
      end
    end

    // Data is kept after Ack so the consumer may re-read the last word.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_data[gi] <= '0;
      end else if (w_load[gi]) begin
        r_data[gi] <= Data_In;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Invalid-selector reporting.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sel_error <= 1'b0;
    end else begin
      r_sel_error <= w_drop;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_drop_count <= '0;
    end else if (w_drop && (r_drop_count != c_CNT_MAX)) begin
      r_drop_count <= r_drop_count + c_CNT_ONE;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs.
  // --------------------------------------------------------------------------
  assign REG1_Out   = r_data[0];
  assign REG2_Out   = r_data[1];
  assign REG3_Out   = r_data[2];
  assign Out_Valid  = w_full;
  assign Sel_Error  = r_sel_error;
  assign Drop_Count = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_demultiplexor_1_3_16b.sv
`default_nettype none
// ============================================================================
// Module      : tb_demultiplexor_1_3_16b
// Description : Self-checking bench for demultiplexor_1_3_16b. Directed
//               scenarios followed by randomized traffic, all compared
//               against a slot-level behavioural model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_demultiplexor_1_3_16b;

  localparam int WIDTH     = 16;
  localparam int CNT_WIDTH = 8;
  localparam int CNT_MAX   = (1 << CNT_WIDTH) - 1;

  logic                 clk;
  logic                 reset;
  logic [WIDTH-1:0]     Data_In;
  logic [1:0]           Selector;
  logic                 Enable;
  logic                 In_Valid;
  logic                 In_Ready;
  logic [2:0]           Ack;
  logic [WIDTH-1:0]     REG1_Out;
  logic [WIDTH-1:0]     REG2_Out;
  logic [WIDTH-1:0]     REG3_Out;
  logic [2:0]           Out_Valid;
  logic                 Sel_Error;
  logic [CNT_WIDTH-1:0] Drop_Count;

  demultiplexor_1_3_16b #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .Data_In    (Data_In),
    .Selector   (Selector),
    .Enable     (Enable),
    .In_Valid   (In_Valid),
    .In_Ready   (In_Ready),
    .Ack        (Ack),
    .REG1_Out   (REG1_Out),
    .REG2_Out   (REG2_Out),
    .REG3_Out   (REG3_Out),
    .Out_Valid  (Out_Valid),
    .Sel_Error  (Sel_Error),
    .Drop_Count (Drop_Count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: three mailboxes, an error pulse and a drop tally.
  int       m_reg   [3];
  bit       m_full  [3];
  bit       m_err;
  int       m_drops;
  bit       m_acc;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h @%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    if (!Enable) return 1'b0;
    if (Selector == 2'd3) return 1'b1;
    return !m_full[Selector] || Ack[Selector];
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 3; i++) begin
      m_reg[i]  = 0;
      m_full[i] = 1'b0;
    end
    m_err   = 1'b0;
    m_drops = 0;
  endtask

  task automatic check_outputs(input string ph);
    chk({ph, ":reg1"}, 32'(REG1_Out), 32'(m_reg[0]));
    chk({ph, ":reg2"}, 32'(REG2_Out), 32'(m_reg[1]));
    chk({ph, ":reg3"}, 32'(REG3_Out), 32'(m_reg[2]));
    chk({ph, ":valid"}, 32'(Out_Valid), {29'd0, m_full[2], m_full[1], m_full[0]});
    chk({ph, ":sel_err"}, 32'(Sel_Error), 32'(m_err));
    chk({ph, ":drops"}, 32'(Drop_Count), 32'(m_drops));
  endtask

  // Called just after a rising edge with inputs already set; advances one
  // clock and checks everything the edge should have produced.
  task automatic step(input string ph);
    bit acc;
    int s;
    #1;
    chk({ph, ":in_ready"}, 32'(In_Ready), 32'(m_ready()));
    acc = In_Valid && m_ready();
    s   = int'(Selector);
    @(posedge clk);
    m_err = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (acc && s == i) begin
        m_reg[i]  = int'(Data_In);
        m_full[i] = 1'b1;
      end else if (Ack[i]) begin
        m_full[i] = 1'b0;
      end
    end
    if (acc && s == 3) begin
      m_err = 1'b1;
      if (m_drops < CNT_MAX) m_drops++;
    end
    m_acc = acc;
    #1;
    check_outputs(ph);
  endtask

  task automatic drive(input bit v, input logic [1:0] s, input logic [15:0] d,
                       input logic [2:0] a, input bit en);
    In_Valid = v;
    Selector = s;
    Data_In  = d;
    Ack      = a;
    Enable   = en;
  endtask

  // Mid-cycle asynchronous reset; outputs must clear before any clock edge.
  task automatic async_reset(input string ph);
    drive(1'b0, 2'd0, 16'h0, 3'b000, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    m_clear();
    check_outputs(ph);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 2'd0, 16'h0, 3'b000, 1'b0);
    m_clear();
    m_acc = 1'b0;
    #12;
    check_outputs("por");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // First accept lands in REG2; slot 1 then reports not ready.
    drive(1'b1, 2'd1, 16'hA5A5, 3'b000, 1'b1);
    step("t1_acc");
    chk("t1_reg2", 32'(REG2_Out), 32'h0000A5A5);
    drive(1'b1, 2'd1, 16'h0BAD, 3'b000, 1'b1);
    #1;
    chk("t1_rdy_low", 32'(In_Ready), 32'd0);
    drive(1'b0, 2'd1, 16'h0000, 3'b010, 1'b1);
    step("t1_drain");

    // Full REG1 blocks, then Ack in the same cycle lets the word through.
    drive(1'b1, 2'd0, 16'h1111, 3'b000, 1'b1);
    step("t2_fill");
    drive(1'b1, 2'd0, 16'h2222, 3'b000, 1'b1);
    step("t2_block");
    chk("t2_reg1_held", 32'(REG1_Out), 32'h00001111);
    drive(1'b1, 2'd0, 16'h2222, 3'b001, 1'b1);
    step("t2_pass");
    chk("t2_reg1_new", 32'(REG1_Out), 32'h00002222);

    // Other full slots do not block; a joint Ack empties both.
    drive(1'b1, 2'd2, 16'h3333, 3'b000, 1'b1);
    step("t3_fill3");
    chk("t3_valid", 32'(Out_Valid), 32'b101);
    drive(1'b0, 2'd0, 16'h0, 3'b101, 1'b1);
    step("t3_ack");
    chk("t3_reg3_kept", 32'(REG3_Out), 32'h00003333);

    // Long run of invalid selectors drives the counter into saturation.
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 2'd3, 16'(i), 3'b000, 1'b1);
      step("t4_drop");
    end
    chk("t4_sat", 32'(Drop_Count), 32'hFF);
    drive(1'b0, 2'd3, 16'h0, 3'b000, 1'b1);
    step("t4_err_off");

    // Disabled block refuses words; enabling lets the held word load.
    drive(1'b1, 2'd0, 16'h4444, 3'b000, 1'b0);
    step("t5_dis");
    drive(1'b1, 2'd0, 16'h4444, 3'b000, 1'b1);
    step("t5_en");

    // Async reset with all slots full and five drops recorded.
    async_reset("t6_pre");
    drive(1'b1, 2'd0, 16'hAAAA, 3'b000, 1'b1); step("t6_f1");
    drive(1'b1, 2'd1, 16'hBBBB, 3'b000, 1'b1); step("t6_f2");
    drive(1'b1, 2'd2, 16'hCCCC, 3'b000, 1'b1); step("t6_f3");
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2'd3, 16'hDEAD, 3'b000, 1'b1);
      step("t6_drop");
    end
    chk("t6_setup", 32'(Drop_Count), 32'd5);
    async_reset("t6_rst");
    drive(1'b1, 2'd1, 16'hA5A5, 3'b000, 1'b1);
    step("t6_after");

    // Randomized traffic; the producer holds an unaccepted word stable.
    drive(1'b0, 2'd0, 16'h0, 3'b000, 1'b1);
    m_acc = 1'b1;
    for (int i = 0; i < 600; i++) begin
      logic [1:0]  s;
      logic [15:0] d;
      logic [2:0]  a;
      bit          en;
      bit          v;
      a  = 3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7));
      en = ($urandom_range(0, 9) != 0);
      if (In_Valid && !m_acc) begin
        drive(1'b1, Selector, Data_In, a, en);
      end else begin
        v = ($urandom_range(0, 3) != 0);
        s = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        d = 16'($urandom);
        drive(v, s, d, a, en);
      end
      step("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
